// File: rtl/csr_uart_fifo_pkg.sv
// Shared definitions for the CSR-mapped UART: FSM state encoding, CSR modify
// codes and the status word bit positions. Imported by the RTL and the bench.
package csr_uart_fifo_pkg;

    // Common state encoding for both the TX and the RX frame FSMs.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StData  = 2'd2,
        StStop  = 2'd3
    } uart_state_e;

    localparam logic [2:0] ModifyWrite = 3'd1;

    // Status word layout; [7:0] carries the received byte, [31:13] read as zero.
    localparam int unsigned StatRxValid   = 8;
    localparam int unsigned StatTxFull    = 9;
    localparam int unsigned StatTxBusy    = 10;
    localparam int unsigned StatRxOverrun = 11;
    localparam int unsigned StatTxDrop    = 12;

    function automatic logic [31:0] pack_status(
        input logic [7:0] rx_byte,
        input logic       rx_valid,
        input logic       tx_full,
        input logic       tx_busy,
        input logic       rx_overrun,
        input logic       tx_drop
    );
        logic [31:0] s;
        s                = '0;
        s[7:0]           = rx_byte;
        s[StatRxValid]   = rx_valid;
        s[StatTxFull]    = tx_full;
        s[StatTxBusy]    = tx_busy;
        s[StatRxOverrun] = rx_overrun;
        s[StatTxDrop]    = tx_drop;
        return s;
    endfunction

endpackage

// File: rtl/csr_uart_fifo_if.sv
// CSR bus bundle for csr_uart_fifo.
//   read   : read strobe, qualified by addr in the same cycle
//   modify : modify code, applies to the address presented one cycle earlier
//   wdata  : write data, valid with modify
//   addr   : CSR address
//   rdata  : read data, zero unless returning a read
//   valid  : combinational address hit
interface csr_uart_fifo_if;
    logic        read;
    logic [2:0]  modify;
    logic [31:0] wdata;
    logic [11:0] addr;
    logic [31:0] rdata;
    logic        valid;

    modport master (output read, output modify, output wdata, output addr,
                    input rdata, input valid);
    modport slave  (input read, input modify, input wdata, input addr,
                    output rdata, output valid);
endinterface

// File: rtl/uart_fifo.sv
// Synchronous FIFO with first-word fall-through read port.
//   clk, rstn   : clock, asynchronous active-low reset
//   push, wdata : enqueue (ignored when full)
//   pop, rdata  : dequeue (ignored when empty); rdata shows the head entry
//   full, empty : occupancy flags
module uart_fifo #(
    parameter int unsigned Width     = 8,
    parameter int unsigned DepthLog2 = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [Width-1:0] wdata,
    input  logic             pop,
    output logic [Width-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int unsigned Depth = 1 << DepthLog2;

    logic [Width-1:0]   mem [Depth];
    // One extra pointer bit separates the full and empty cases.
    logic [DepthLog2:0] wr_ptr_q, rd_ptr_q;
    logic               do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[DepthLog2] != rd_ptr_q[DepthLog2]) &&
                     (wr_ptr_q[DepthLog2-1:0] == rd_ptr_q[DepthLog2-1:0]);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr_q[DepthLog2-1:0]];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + (DepthLog2 + 1)'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + (DepthLog2 + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q[DepthLog2-1:0]] <= wdata;
    end

endmodule

// File: rtl/csr_uart_fifo.sv
// CSR-mapped 8N1 UART with a TX FIFO and a single-byte RX holding register.
//   clk, rstn : clock, asynchronous active-low reset
//   bus       : CSR slave port (read/modify/wdata/addr in, rdata/valid out)
//   tx        : serial transmit line, idle high
//   rx        : serial receive line, asynchronous, idle high
// A write (modify==1 to BASE_ADDR) queues wdata[7:0]; a read returns the status word.
module csr_uart_fifo
    import csr_uart_fifo_pkg::*;
#(
    parameter logic [11:0] BASE_ADDR  = 12'hBC0,
    parameter int unsigned DIVISOR    = 8,
    parameter int unsigned DEPTH_LOG2 = 2
) (
    input  logic            clk,
    input  logic            rstn,
    csr_uart_fifo_if.slave  bus,
    output logic            tx,
    input  logic            rx
);
    localparam int unsigned    CntW     = $clog2(DIVISOR + 1);
    localparam logic [CntW-1:0] BitLast  = CntW'(DIVISOR - 1);
    localparam logic [CntW-1:0] HalfLast = CntW'(DIVISOR / 2 - 1);

    // CSR decode
    logic [11:0] q_addr;
    logic        wr_hit, rd_hit;
    logic        unused_wdata;

    assign bus.valid    = (bus.addr == BASE_ADDR);
    assign wr_hit       = (bus.modify == ModifyWrite) && (q_addr == BASE_ADDR);
    assign rd_hit       = bus.read && bus.valid;
    assign unused_wdata = ^bus.wdata[31:8];

    // TX FIFO
    logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0] fifo_rdata;

    assign fifo_push = wr_hit & ~fifo_full;

    uart_fifo #(
        .Width     (8),
        .DepthLog2 (DEPTH_LOG2)
    ) u_tx_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (fifo_push),
        .wdata (bus.wdata[7:0]),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // TX state
    uart_state_e     tx_state_q, tx_state_d;
    logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]      tx_idx_q, tx_idx_d;
    logic [7:0]      tx_shift_q, tx_shift_d;
    logic            tx_q, tx_d;
    logic            tx_busy;

    // RX state
    logic [1:0]      rx_sync_q;
    logic            rx_s, rx_prev_q;
    uart_state_e     rx_state_q, rx_state_d;
    logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_idx_q, rx_idx_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic            rx_good;

    // Flags and read data
    logic [7:0]  rx_byte_q, rx_byte_d;
    logic        rx_valid_q, rx_valid_d;
    logic        rx_overrun_q, rx_overrun_d;
    logic        tx_drop_q, tx_drop_d;
    logic [31:0] rdata_q, rdata_d;

    assign rx_s      = rx_sync_q[1];
    assign tx        = tx_q;
    assign bus.rdata = rdata_q;
    assign tx_busy   = ~fifo_empty || (tx_state_q != StIdle);

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_idx_d   = tx_idx_q;
        tx_shift_d = tx_shift_q;
        fifo_pop   = 1'b0;
        case (tx_state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    tx_shift_d = fifo_rdata;
                    tx_cnt_d   = '0;
                    tx_state_d = StStart;
                end
            end
            StStart: begin
                if (tx_cnt_q == BitLast) begin
                    tx_cnt_d   = '0;
                    tx_idx_d   = '0;
                    tx_state_d = StData;
                end else begin
                    tx_cnt_d = tx_cnt_q + CntW'(1);
                end
            end
            StData: begin
                if (tx_cnt_q == BitLast) begin
                    tx_cnt_d   = '0;
                    tx_shift_d = tx_shift_q >> 1;
                    tx_idx_d   = tx_idx_q + 3'd1;
                    if (tx_idx_q == 3'd7) tx_state_d = StStop;
                end else begin
                    tx_cnt_d = tx_cnt_q + CntW'(1);
                end
            end
            StStop: begin
                if (tx_cnt_q == BitLast) begin
                    tx_cnt_d = '0;
                    // Chain straight into the next frame with no idle bit.
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        tx_shift_d = fifo_rdata;
                        tx_state_d = StStart;
                    end else begin
                        tx_state_d = StIdle;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CntW'(1);
                end
            end
            default: tx_state_d = StIdle;
        endcase

        // Line level follows the next state so tx is a clean flop output.
        case (tx_state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = tx_shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_idx_d   = rx_idx_q;
        rx_shift_d = rx_shift_q;
        rx_good    = 1'b0;
        case (rx_state_q)
            StIdle: begin
                if (rx_prev_q && !rx_s) begin
                    rx_cnt_d   = '0;
                    rx_state_d = StStart;
                end
            end
            StStart: begin
                // Half a bit after the edge: still low means a real start bit.
                if (rx_cnt_q == HalfLast) begin
                    rx_cnt_d   = '0;
                    rx_idx_d   = '0;
                    rx_state_d = rx_s ? StIdle : StData;
                end else begin
                    rx_cnt_d = rx_cnt_q + CntW'(1);
                end
            end
            StData: begin
                if (rx_cnt_q == BitLast) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s, rx_shift_q[7:1]};
                    rx_idx_d   = rx_idx_q + 3'd1;
                    if (rx_idx_q == 3'd7) rx_state_d = StStop;
                end else begin
                    rx_cnt_d = rx_cnt_q + CntW'(1);
                end
            end
            StStop: begin
                if (rx_cnt_q == BitLast) begin
                    rx_cnt_d   = '0;
                    rx_good    = rx_s;
                    rx_state_d = StIdle;
                end else begin
                    rx_cnt_d = rx_cnt_q + CntW'(1);
                end
            end
            default: rx_state_d = StIdle;
        endcase
    end

    // Setting events take priority over the clear-on-read.
    always_comb begin
        rx_byte_d    = rx_good ? rx_shift_q : rx_byte_q;
        rx_valid_d   = rx_good | (rx_valid_q & ~rd_hit);
        rx_overrun_d = (rx_good & rx_valid_q) | (rx_overrun_q & ~rd_hit);
        tx_drop_d    = (wr_hit & fifo_full) | (tx_drop_q & ~rd_hit);
        rdata_d      = '0;
        if (rd_hit) begin
            rdata_d = pack_status(rx_byte_q, rx_valid_q, fifo_full, tx_busy,
                                  rx_overrun_q, tx_drop_q);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q_addr       <= '0;
            tx_state_q   <= StIdle;
            tx_cnt_q     <= '0;
            tx_idx_q     <= '0;
            tx_shift_q   <= '0;
            tx_q         <= 1'b1;
            rx_sync_q    <= 2'b11;
            rx_prev_q    <= 1'b1;
            rx_state_q   <= StIdle;
            rx_cnt_q     <= '0;
            rx_idx_q     <= '0;
            rx_shift_q   <= '0;
            rx_byte_q    <= '0;
            rx_valid_q   <= 1'b0;
            rx_overrun_q <= 1'b0;
            tx_drop_q    <= 1'b0;
            rdata_q      <= '0;
        end else begin
            q_addr       <= bus.addr;
            tx_state_q   <= tx_state_d;
            tx_cnt_q     <= tx_cnt_d;
            tx_idx_q     <= tx_idx_d;
            tx_shift_q   <= tx_shift_d;
            tx_q         <= tx_d;
            rx_sync_q    <= {rx_sync_q[0], rx};
            rx_prev_q    <= rx_s;
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_idx_q     <= rx_idx_d;
            rx_shift_q   <= rx_shift_d;
            rx_byte_q    <= rx_byte_d;
            rx_valid_q   <= rx_valid_d;
            rx_overrun_q <= rx_overrun_d;
            tx_drop_q    <= tx_drop_d;
            rdata_q      <= rdata_d;
        end
    end

endmodule

// File: tb/tb_csr_uart_fifo.sv
// Directed bench for csr_uart_fifo: TX framing, FIFO full/drop, RX receive,
// overrun, glitch/framing rejection and mid-frame reset.
module tb_csr_uart_fifo;
    import csr_uart_fifo_pkg::*;

    localparam logic [11:0] Base = 12'hBC0;
    localparam int          Div  = 8;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    logic tx;
    logic rx   = 1'b1;

    csr_uart_fifo_if bus ();

    csr_uart_fifo #(
        .BASE_ADDR  (Base),
        .DIVISOR    (Div),
        .DEPTH_LOG2 (2)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus),
        .tx   (tx),
        .rx   (rx)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  exp_tx [5];
    logic [31:0] st;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic csr_read(output logic [31:0] val);
        bus.read = 1'b1;
        bus.addr = Base;
        tick();
        bus.read = 1'b0;
        val      = bus.rdata;
    endtask

    task automatic csr_write(input logic [7:0] d);
        bus.addr = Base;
        tick();
        bus.modify = 3'd1;
        bus.wdata  = {24'hABCDEF, d};
        tick();
        bus.modify = 3'd0;
    endtask

    // Waits for a start bit, then checks every cycle of n contiguous frames.
    task automatic tx_expect(input int n);
        int   budget = 0;
        int   errs;
        int   b;
        logic expb;
        while (tx !== 1'b0 && budget < 200) begin
            tick();
            budget++;
        end
        check_val("tx_start_seen", 32'(budget < 200), 32'd1);
        if (budget >= 200) return;
        for (int f = 0; f < n; f++) begin
            errs = 0;
            for (int c = 0; c < 10 * Div; c++) begin
                b = c / Div;
                if (b == 0)      expb = 1'b0;
                else if (b == 9) expb = 1'b1;
                else             expb = exp_tx[f][b-1];
                if (tx !== expb) errs++;
                tick();
            end
            check_val($sformatf("tx_frame%0d_bad_cycles", f), 32'(errs), 32'd0);
        end
    endtask

    task automatic send_rx(input logic [7:0] d, input logic stop);
        rx = 1'b0;
        tick(Div);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            tick(Div);
        end
        rx = stop;
        tick(Div);
        rx = 1'b1;
        tick(4);
    endtask

    initial begin
        int budget;
        int lows;

        bus.read   = 1'b0;
        bus.modify = 3'd0;
        bus.wdata  = '0;
        bus.addr   = '0;
        tick(3);

        // Reset state
        check_val("reset_tx", 32'(tx), 32'd1);
        check_val("reset_rdata", bus.rdata, 32'd0);
        rstn = 1'b1;
        tick(2);
        bus.addr = Base;
        #1 check_val("valid_hit", 32'(bus.valid), 32'd1);
        bus.addr = 12'hBC1;
        #1 check_val("valid_miss", 32'(bus.valid), 32'd0);
        csr_read(st);
        check_val("status_after_reset", st, 32'h0);

        // Non-write modify code must not queue anything
        bus.addr = Base;
        tick();
        bus.modify = 3'd2;
        bus.wdata  = 32'h77;
        tick();
        bus.modify = 3'd0;
        tick(3);
        check_val("modify2_tx_idle", 32'(tx), 32'd1);
        csr_read(st);
        check_val("modify2_ignored", st, 32'h0);

        // Single frame 0x55, then busy must be clear
        exp_tx[0] = 8'h55;
        csr_write(8'h55);
        tx_expect(1);
        csr_read(st);
        check_val("busy_clear_after_80", st, 32'h0);

        // Five back-to-back writes fill the 4-deep FIFO; sixth is dropped
        for (int i = 0; i < 5; i++) exp_tx[i] = 8'(i + 1);
        fork
            tx_expect(5);
            begin
                bus.addr = Base;
                tick();
                for (int i = 1; i <= 5; i++) begin
                    bus.modify = 3'd1;
                    bus.wdata  = 32'(i);
                    tick();
                end
                bus.modify = 3'd0;
                csr_read(st);
                check_val("fifo_full_no_drop", st, 32'h600);
                csr_write(8'h66);
                csr_read(st);
                check_val("drop_sticky", st, 32'h1600);
                csr_read(st);
                check_val("drop_cleared", st, 32'h600);
            end
        join
        csr_read(st);
        check_val("idle_after_burst", st, 32'h0);

        // RX single byte; a read at another address must not clear rx_valid
        send_rx(8'hA3, 1'b1);
        bus.read = 1'b1;
        bus.addr = 12'h123;
        tick();
        bus.read = 1'b0;
        check_val("rdata_wrong_addr", bus.rdata, 32'h0);
        csr_read(st);
        check_val("rx_a3_first", st, 32'h1A3);
        csr_read(st);
        check_val("rx_a3_second", st, 32'h0A3);

        // Overrun
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        csr_read(st);
        check_val("rx_overrun", st, 32'h922);
        csr_read(st);
        check_val("rx_overrun_cleared", st, 32'h022);

        // Glitch and framing error leave rx_valid clear
        rx = 1'b0;
        tick(2);
        rx = 1'b1;
        tick(12 * Div);
        csr_read(st);
        check_val("rx_glitch_rejected", st, 32'h022);
        send_rx(8'h5A, 1'b0);
        tick(2 * Div);
        csr_read(st);
        check_val("rx_framing_discard", st, 32'h022);

        // Reset during the data bits of 0xFF
        csr_write(8'hFF);
        budget = 0;
        while (tx !== 1'b0 && budget < 200) begin
            tick();
            budget++;
        end
        check_val("ff_start_seen", 32'(budget < 200), 32'd1);
        tick(20);
        rstn = 1'b0;
        tick();
        check_val("tx_in_reset", 32'(tx), 32'd1);
        check_val("rdata_in_reset", bus.rdata, 32'h0);
        rstn = 1'b1;
        tick();
        check_val("tx_after_reset", 32'(tx), 32'd1);
        csr_read(st);
        check_val("status_after_midframe_reset", st, 32'h0);
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            if (tx !== 1'b1) lows++;
            tick();
        end
        check_val("tx_idle_after_reset", 32'(lows), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/csr_uart_fifo.md
CSR_UART_FIFO -- requirements
Module: csr_uart_fifo

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 12'hBC0: CSR address of the UART data/status register.
REQ-002 SHALL have parameter DIVISOR, default 8: clock cycles per serial bit (valid range 4..65535).
REQ-003 SHALL have parameter DEPTH_LOG2, default 2: TX FIFO depth is 2**DEPTH_LOG2 entries.
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-005 SHALL have port rstn  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port read  input  1  CSR read strobe, qualified by addr in the same cycle.
REQ-007 SHALL have port modify  input  3  CSR modify code; applies to the address latched one cycle earlier.
REQ-008 SHALL have port wdata  input  32  CSR write data, valid with modify.
REQ-009 SHALL have port addr  input  12  CSR address.
REQ-010 SHALL have port rdata  output  32  CSR read data; zero unless returning a read.
REQ-011 SHALL have port valid  output  1  combinational: high when addr==BASE_ADDR.
REQ-012 SHALL have port tx  output  1  serial transmit line, idle high.
REQ-013 SHALL have port rx  input  1  serial receive line, asynchronous, idle high.

Function
REQ-014 SHALL register addr every cycle (q_addr); a write occurs when modify==1 and q_addr==BASE_ADDR; other modify codes SHALL be ignored.
REQ-015 SHALL push wdata[7:0] into the TX FIFO on a write when not full; a write while full SHALL be dropped and SHALL set sticky tx_drop.
REQ-016 SHALL return rdata one cycle after read with addr==BASE_ADDR: [7:0] rx byte, [8] rx_valid, [9] tx_full, [10] tx_busy (FIFO non-empty or shifter active), [11] rx_overrun, [12] tx_drop, [31:13] zero.
REQ-017 SHALL clear rx_valid, rx_overrun, tx_drop in the cycle the read is accepted; an event setting a flag in that same cycle SHALL win (flag stays set).
REQ-018 TX FSM SHALL have states IDLE, START, DATA, STOP; IDLE->START when FIFO non-empty (pop in that cycle), START 1 bit low, DATA 8 bits LSB first, STOP 1 bit high, then IDLE; each bit lasts exactly DIVISOR cycles.
REQ-019 SHALL allow simultaneous push and pop; FIFO pointers SHALL wrap modulo depth with an extra bit for full/empty.
REQ-020 Back-to-back frames SHALL have no idle gap: STOP end with FIFO non-empty goes directly to START.
REQ-021 rx SHALL pass a 2-flop synchronizer; RX FSM IDLE->START on synchronized falling edge, samples at bit mid-point (DIVISOR/2 after edge, then every DIVISOR), states IDLE, START, DATA, STOP.
REQ-022 A START sample reading high SHALL abort to IDLE (glitch); a STOP sample reading low SHALL discard the byte (framing error) and return to IDLE.
REQ-023 A good byte SHALL load rx byte and set rx_valid; if rx_valid already set, byte SHALL overwrite and set rx_overrun.
REQ-024 Bit-period counters SHALL be $clog2(DIVISOR+1) bits wide and never wrap mid-bit.

Reset
REQ-025 On rstn low: tx=1, rdata=0, FIFO empty, both FSMs IDLE, all flags 0, rx byte 0, synchronizer flops 1.
REQ-026 Reset mid-frame SHALL abort immediately; tx high in the next cycle rstn is high.

Structure
REQ-027 State encodings (IDLE/START/DATA/STOP) and status-bit positions SHALL live in a shared package used by RTL and bench.
REQ-028 TX FIFO SHALL be a sub-module uart_fifo (parameterised width/depth, push/pop/full/empty).

Verification
REQ-029 Write 0x55 to BASE_ADDR, DIVISOR=8 -> tx low 8 cycles, bits 1,0,1,0,1,0,1,0 each 8 cycles, high 8 cycles; tx_busy clears after 80 cycles.
REQ-030 Five writes 0x01..0x05 back-to-back, depth 4 -> first pops to shifter, all five sent contiguously, tx_drop stays 0; sixth write while full -> dropped, rdata[12]=1.
REQ-031 Drive rx frame 0xA3 -> read returns 0x1A3; second read returns 0x0A3 with [8]=0.
REQ-032 Two rx frames 0x11, 0x22 without read -> read returns byte 0x22, [8]=1, [11]=1.
REQ-033 rx low pulse of 2 cycles; frame with stop bit low -> rx_valid stays 0.
REQ-034 Assert rstn low during DATA of 0xFF -> tx=1 after release, FIFO empty, status read 0.
